// File: rtl/crossbar_pkg.sv
// -----------------------------------------------------------------------------
// crossbar_pkg
// Shared constants and helpers for the N-port input-queued crossbar.
//   STAT_W   : width of each per-output grant statistic counter.
//   dw_of()  : destination field width for a given port count.
//   lane_lo(): low bit index of lane <lane> in a flat bus of <w>-bit lanes.
//   lane_hi(): high bit index of the same lane.
// -----------------------------------------------------------------------------
package crossbar_pkg;

    localparam int STAT_W = 32;

    // A 2-port crossbar still needs one destination bit.
    function automatic int dw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

    function automatic int lane_hi(input int lane, input int w);
        return lane * w + w - 1;
    endfunction

endpackage

// File: rtl/crossbar_nxn_if.sv
// -----------------------------------------------------------------------------
// crossbar_nxn_if
// Ingress push bus and egress valid/ready bus of the crossbar.
//   in_data  [N*WIDTH] : ingress words, lane i = [i*WIDTH +: WIDTH]
//   in_dest  [N*DW]    : destination output per ingress lane
//   in_valid [N]       : push request per ingress lane
//   in_ready [N]       : ingress FIFO not full
//   out_data [N*WIDTH] : registered egress words, one lane per output
//   out_valid[N]       : egress lane holds a word
//   out_ready[N]       : consumer accepts the word on its lane
// Modports: slave = crossbar side, master = ingress adapter / consumer side.
// -----------------------------------------------------------------------------
interface crossbar_nxn_if #(
    parameter int N     = 4,
    parameter int WIDTH = 320
);
    import crossbar_pkg::*;

    localparam int DW = dw_of(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N*DW-1:0]    in_dest;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [N*WIDTH-1:0] out_data;
    logic [N-1:0]       out_valid;
    logic [N-1:0]       out_ready;

    modport slave (
        input  in_data, in_dest, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    modport master (
        output in_data, in_dest, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

endinterface

// File: rtl/crossbar_nxn_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter for one crossbar output.
//   clk, rst : clock, asynchronous active-high reset
//   req[N]   : requesting inputs
//   en       : output stage can load this cycle
//   grant[N] : one-hot grant (combinational, same cycle as req)
//   ptr      : current search start; moves to winner+1 after a grant
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 en,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] ptr
);
    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] idx;
    logic          found;

    // N is a power of two, so PW-bit addition wraps modulo N for free.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int off = 0; off < N; off++) begin
            idx = ptr_q + PW'(off);
            if (!found && en && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_d      = idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/crossbar_nxn.sv
// -----------------------------------------------------------------------------
// crossbar_nxn
// N-port input-queued crossbar. Each input has a DEPTH-entry FIFO; the FIFO
// head requests exactly one output; a round-robin arbiter per output picks a
// winner, which pops its FIFO into that output's registered valid/ready stage.
//   clk            : clock, rising edge
//   rst            : asynchronous active-high reset
//   bus            : crossbar_nxn_if.slave (ingress push + egress valid/ready)
//   stat_grant_cnt : [N*32] saturating grant count per output, present only
//                    when CROSSBAR_STATS_EN is defined
// Head-of-line blocking is intentional: a blocked head stalls its FIFO.
// -----------------------------------------------------------------------------
module crossbar_nxn
    import crossbar_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 320,
    parameter int DEPTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    crossbar_nxn_if.slave      bus
`ifdef CROSSBAR_STATS_EN
    ,
    output logic [N*STAT_W-1:0] stat_grant_cnt
`endif
);
    localparam int DW = dw_of(N);
    localparam int AW = $clog2(DEPTH);

    logic [N-1:0]            in_ready;
    logic [N-1:0]            nonempty;
    logic [N-1:0]            pop;
    logic [WIDTH-1:0]        head_data [N];
    logic [DW-1:0]           head_dest [N];
    logic [N-1:0][N-1:0]     req;      // [output][input]
    logic [N-1:0][N-1:0]     grant;    // [output][input]
    logic [N-1:0]            load_en;
    logic [$clog2(N)-1:0]    rr_ptr [N];

    logic [N-1:0]            out_valid_q, out_valid_d;
    logic [N-1:0][WIDTH-1:0] out_data_q, out_data_d;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    // ---------------- ingress FIFOs ----------------
    for (genvar i = 0; i < N; i++) begin : g_fifo
        logic [AW:0]      wr_ptr_q, wr_ptr_d;
        logic [AW:0]      rd_ptr_q, rd_ptr_d;
        logic [AW:0]      count;
        logic             push;
        logic [WIDTH-1:0] mem_data [DEPTH];
        logic [DW-1:0]    mem_dest [DEPTH];

        // Extra wrap bit lets count span 0..DEPTH inclusive.
        assign count       = wr_ptr_q - rd_ptr_q;
        // Ready depends only on the registered count: no pass-through when full.
        assign in_ready[i] = (count != (AW+1)'(DEPTH));
        assign nonempty[i] = (count != '0);
        assign push        = bus.in_valid[i] & in_ready[i];
        assign head_data[i] = mem_data[rd_ptr_q[AW-1:0]];
        assign head_dest[i] = mem_dest[rd_ptr_q[AW-1:0]];

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop[i]) rd_ptr_d = rd_ptr_q + 1'b1;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
            end
        end

        // Storage needs no reset; pointers alone define what is valid.
        always_ff @(posedge clk) begin
            if (push) begin
                mem_data[wr_ptr_q[AW-1:0]] <= bus.in_data[lane_lo(i, WIDTH) +: WIDTH];
                mem_dest[wr_ptr_q[AW-1:0]] <= bus.in_dest[lane_lo(i, DW) +: DW];
            end
        end
    end

    // ---------------- request matrix ----------------
    always_comb begin
        req     = '0;
        load_en = '0;
        for (int j = 0; j < N; j++) begin
            load_en[j] = ~out_valid_q[j] | bus.out_ready[j];
            for (int i = 0; i < N; i++)
                req[j][i] = nonempty[i] & (head_dest[i] == DW'(j));
        end
    end

    // ---------------- per-output arbiters ----------------
    for (genvar j = 0; j < N; j++) begin : g_arb
        rr_arbiter #(.N(N)) u_arb (
            .clk   (clk),
            .rst   (rst),
            .req   (req[j]),
            .en    (load_en[j]),
            .grant (grant[j]),
            .ptr   (rr_ptr[j])
        );
    end

    // ---------------- output stages ----------------
    // An input requests only one output, so OR-ing grants never double-pops.
    always_comb begin
        pop         = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        for (int j = 0; j < N; j++) begin
            pop = pop | grant[j];
            if (|grant[j]) begin
                out_valid_d[j] = 1'b1;
                for (int i = 0; i < N; i++)
                    if (grant[j][i]) out_data_d[j] = head_data[i];
            end else if (bus.out_ready[j]) begin
                // Data is left in place after the handshake.
                out_valid_d[j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef CROSSBAR_STATS_EN
    // ---------------- grant statistics ----------------
    logic [N-1:0][STAT_W-1:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        for (int j = 0; j < N; j++)
            if ((|grant[j]) && (stat_q[j] != '1)) stat_d[j] = stat_q[j] + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stat_q <= '0;
        else     stat_q <= stat_d;
    end

    assign stat_grant_cnt = stat_q;
`endif

endmodule

// File: tb/tb_crossbar_nxn.sv
// -----------------------------------------------------------------------------
// tb_crossbar_nxn
// Directed bench for crossbar_nxn at N=4, WIDTH=32, DEPTH=4. Inputs change and
// outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_crossbar_nxn;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int DW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    crossbar_nxn_if #(.N(N), .WIDTH(W)) bus ();

`ifdef CROSSBAR_STATS_EN
    logic [N*32-1:0] stat_grant_cnt;
`endif

    crossbar_nxn #(.N(N), .WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef CROSSBAR_STATS_EN
        ,
        .stat_grant_cnt (stat_grant_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = '0;
        bus.in_data  = '0;
        bus.in_dest  = '0;
    endtask

    function automatic logic [W-1:0] lane(input int j);
        return bus.out_data[j*W +: W];
    endfunction

    task automatic test_reset();
        idle_inputs();
        bus.out_ready = '1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.out_valid !== 4'b0000) begin
            n_err++; $display("FAIL reset_out_valid_in_rst got %b want 0000", bus.out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 4'b1111) begin
            n_err++; $display("FAIL reset_in_ready got %b want 1111", bus.in_ready);
        end
        n_cmp++;
        if (bus.out_valid !== 4'b0000) begin
            n_err++; $display("FAIL reset_out_valid got %b want 0000", bus.out_valid);
        end
        n_cmp++;
        if (bus.out_data !== '0) begin
            n_err++; $display("FAIL reset_out_data got %h want 0", bus.out_data);
        end
    endtask

    task automatic test_single_path();
        bus.out_ready          = '1;
        bus.in_valid           = 4'b0001;
        bus.in_dest[0 +: DW]   = 2'd2;
        bus.in_data[0 +: W]    = 32'hA5A5_0001;
        step();
        idle_inputs();
        n_cmp++;
        if (bus.out_valid !== 4'b0000) begin
            n_err++; $display("FAIL single_push_edge got %b want 0000", bus.out_valid);
        end
        step();
        n_cmp++;
        if (bus.out_valid !== 4'b0100) begin
            n_err++; $display("FAIL single_out_valid got %b want 0100", bus.out_valid);
        end
        n_cmp++;
        if (lane(2) !== 32'hA5A5_0001) begin
            n_err++; $display("FAIL single_lane2 got %h want a5a50001", lane(2));
        end
        step();
        n_cmp++;
        if (bus.out_valid !== 4'b0000) begin
            n_err++; $display("FAIL single_out_drop got %b want 0000", bus.out_valid);
        end
        n_cmp++;
        if (lane(2) !== 32'hA5A5_0001) begin
            n_err++; $display("FAIL single_data_kept got %h want a5a50001", lane(2));
        end
    endtask

    task automatic test_contention();
        for (int i = 0; i < N; i++) begin
            bus.in_dest[i*DW +: DW] = 2'd1;
            bus.in_data[i*W +: W]   = 32'hC000_0000 | W'(i);
        end
        bus.in_valid = 4'b1111;
        step();
        idle_inputs();
        for (int k = 0; k < N; k++) begin
            step();
            n_cmp++;
            if (bus.out_valid !== 4'b0010) begin
                n_err++; $display("FAIL contention_valid[%0d] got %b want 0010", k, bus.out_valid);
            end
            n_cmp++;
            if (lane(1) !== (32'hC000_0000 | W'(k))) begin
                n_err++; $display("FAIL contention_order[%0d] got %h want %h", k, lane(1), 32'hC000_0000 | W'(k));
            end
        end
        step();
        n_cmp++;
        if (bus.out_valid !== 4'b0000) begin
            n_err++; $display("FAIL contention_end got %b want 0000", bus.out_valid);
        end
    endtask

    task automatic test_fairness();
        int s0 = 0;
        int s2 = 0;
        int got = 0;
        logic [W-1:0] exp;
        bus.out_ready = '1;
        for (int c = 0; c < 14; c++) begin
            bus.in_valid        = {1'b0, bus.in_ready[2], 1'b0, bus.in_ready[0]};
            bus.in_dest         = '0;
            bus.in_data[0 +: W] = {8'h00, 24'(s0)};
            bus.in_data[2*W +: W] = {8'h02, 24'(s2)};
            step();
            if (bus.in_valid[0]) s0++;
            if (bus.in_valid[2]) s2++;
            if (bus.out_valid[0]) begin
                exp = ((got % 2) == 0) ? {8'h00, 24'(got / 2)} : {8'h02, 24'(got / 2)};
                n_cmp++;
                if (lane(0) !== exp) begin
                    n_err++; $display("FAIL fairness_grant[%0d] got %h want %h", got, lane(0), exp);
                end
                got++;
            end
        end
        idle_inputs();
        n_cmp++;
        if (got != 13) begin
            n_err++; $display("FAIL fairness_throughput got %0d want 13", got);
        end
        repeat (12) step();
        n_cmp++;
        if (bus.out_valid !== 4'b0000) begin
            n_err++; $display("FAIL fairness_drain got %b want 0000", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        bus.out_ready = 4'b0111;
        for (int c = 0; c < 8; c++) begin
            bus.in_valid            = {2'b00, bus.in_ready[1], 1'b0};
            bus.in_dest[DW +: DW]   = 2'd3;
            bus.in_data[W +: W]     = 32'hB000_0000 + W'(acc);
            step();
            if (bus.in_valid[1]) acc++;
            if (c >= 1) begin
                n_cmp++;
                if (bus.out_valid[3] !== 1'b1 || lane(3) !== 32'hB000_0000) begin
                    n_err++; $display("FAIL bp_hold[%0d] got v=%b d=%h want v=1 d=b0000000", c, bus.out_valid[3], lane(3));
                end
            end
        end
        idle_inputs();
        n_cmp++;
        if (acc != 5) begin
            n_err++; $display("FAIL bp_accepted got %0d want 5", acc);
        end
        n_cmp++;
        if (bus.in_ready !== 4'b1101) begin
            n_err++; $display("FAIL bp_in_ready got %b want 1101", bus.in_ready);
        end
        bus.out_ready = '1;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (bus.out_valid[3] !== 1'b1 || lane(3) !== 32'hB000_0000 + W'(k)) begin
                n_err++; $display("FAIL bp_drain[%0d] got v=%b d=%h want v=1 d=%h", k, bus.out_valid[3], lane(3), 32'hB000_0000 + W'(k));
            end
            step();
        end
        n_cmp++;
        if (bus.out_valid !== 4'b0000) begin
            n_err++; $display("FAIL bp_drain_end got %b want 0000", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int acc = 0;
        bus.out_ready = 4'b0111;
        for (int c = 0; c < 4; c++) begin
            bus.in_valid          = {2'b00, bus.in_ready[1], 1'b0};
            bus.in_dest[DW +: DW] = 2'd3;
            bus.in_data[W +: W]   = 32'hE000_0000 + W'(acc);
            step();
            if (bus.in_valid[1]) acc++;
        end
        n_cmp++;
        if (bus.out_valid !== 4'b1000) begin
            n_err++; $display("FAIL rstmid_pre got %b want 1000", bus.out_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.out_valid !== 4'b0000) begin
            n_err++; $display("FAIL rstmid_async_valid got %b want 0000", bus.out_valid);
        end
        n_cmp++;
        if (bus.out_data !== '0) begin
            n_err++; $display("FAIL rstmid_async_data got %h want 0", bus.out_data);
        end
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        bus.out_ready = '1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 4'b1111) begin
            n_err++; $display("FAIL rstmid_in_ready got %b want 1111", bus.in_ready);
        end
        for (int c = 0; c < 6; c++) begin
            step();
            n_cmp++;
            if (bus.out_valid !== 4'b0000) begin
                n_err++; $display("FAIL rstmid_stale[%0d] got %b want 0000", c, bus.out_valid);
            end
        end
        bus.in_valid            = 4'b1000;
        bus.in_dest[3*DW +: DW] = 2'd0;
        bus.in_data[3*W +: W]   = 32'h1234_5678;
        step();
        idle_inputs();
        step();
        n_cmp++;
        if (bus.out_valid !== 4'b0001 || lane(0) !== 32'h1234_5678) begin
            n_err++; $display("FAIL rstmid_recover got v=%b d=%h want v=0001 d=12345678", bus.out_valid, lane(0));
        end
    endtask

    initial begin
        idle_inputs();
        bus.out_ready = '1;
        test_reset();
        test_single_path();
        test_contention();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
